// File: rtl/mole_recorder.sv
// Mole recorder: captures timed pad stomps against the music address while recording,
// and replays them as one-cycle mole requests when the same addresses come round again.
module mole_recorder #(
  parameter int DEPTH  = 16,
  parameter int ADDR_W = 23
) (
  input  logic              clk,
  input  logic              reset,
  input  logic              diy_mode,
  input  logic              play,
  input  logic [7:0]        stomp,
  input  logic [ADDR_W-1:0] music_address,
  output logic              request_mole,
  output logic [2:0]        mole_location,
  output logic [4:0]        count,
  output logic              full,
  output logic              recording
);

  localparam int         IDX_W   = (DEPTH > 1) ? $clog2(DEPTH) : 1;
  localparam logic [4:0] DEPTH_C = 5'(DEPTH);

  typedef enum logic [1:0] {IDLE, CLEAR, RECORD, PLAY} state_e;

  typedef struct packed {
    logic [ADDR_W-1:0] addr;
    logic [2:0]        loc;
  } entry_t;

  entry_t mem [DEPTH];

  state_e            state_q, state_d;
  logic [4:0]        count_q, count_d;
  logic [4:0]        rd_ptr_q, rd_ptr_d;
  logic [ADDR_W-1:0] last_addr_q, last_addr_d;
  logic              prev_one_q;
  logic              request_mole_q, request_mole_d;
  logic [2:0]        mole_location_q, mole_location_d;
  logic              full_q, full_d;
  logic              recording_q, recording_d;

  logic       one_hot;
  logic       stomp_evt;
  logic [2:0] pad_loc;
  logic       wr_en;
  entry_t     wr_entry;
  entry_t     rd_entry;

  // Pad index counts from upleft (bit 7) down to downright (bit 0).
  always_comb begin
    // NOTE: every always_comb output gets a default first so no latch is inferred.
    pad_loc = 3'd0;
    for (int i = 0; i < 8; i++) begin
      if (stomp[i]) pad_loc = 3'(7 - i);
    end
  end

  // A slide between pads keeps one_hot high, so only a fresh press is an event.
  assign one_hot   = (stomp != 8'd0) && ((stomp & (stomp - 8'd1)) == 8'd0);
  assign stomp_evt = one_hot && !prev_one_q;
  assign wr_entry  = '{addr: music_address, loc: pad_loc};
  assign rd_entry  = mem[rd_ptr_q[IDX_W-1:0]];

  always_comb begin
    state_d         = state_q;
    count_d         = count_q;
    rd_ptr_d        = rd_ptr_q;
    last_addr_d     = last_addr_q;
    request_mole_d  = 1'b0;
    mole_location_d = mole_location_q;
    wr_en           = 1'b0;

    unique case (state_q)
      IDLE: begin
        if (diy_mode) begin
          state_d = CLEAR;
        end else if (play && (count_q != 5'd0)) begin
          state_d  = PLAY;
          rd_ptr_d = 5'd0;
        end
      end
      CLEAR: begin
        count_d     = 5'd0;
        last_addr_d = '0;
        state_d     = RECORD;
      end
      RECORD: begin
        if (!diy_mode) begin
          state_d = IDLE;
        end else if (stomp_evt && (count_q < DEPTH_C) &&
                     ((count_q == 5'd0) || (music_address > last_addr_q))) begin
          wr_en       = !reset;
          count_d     = count_q + 5'd1;
          last_addr_d = music_address;
        end
      end
      PLAY: begin
        if (!play) begin
          state_d  = IDLE;
          rd_ptr_d = 5'd0;
        end else if ((rd_ptr_q < count_q) && (music_address == rd_entry.addr)) begin
          request_mole_d  = 1'b1;
          mole_location_d = rd_entry.loc;
          rd_ptr_d        = rd_ptr_q + 5'd1;
        end
      end
      default: state_d = IDLE;
    endcase
  end

  assign full_d      = (count_d == DEPTH_C);
  assign recording_d = (state_d == RECORD);

  always_ff @(posedge clk) begin
    if (reset) begin
      state_q         <= IDLE;
      count_q         <= 5'd0;
      rd_ptr_q        <= 5'd0;
      last_addr_q     <= '0;
      prev_one_q      <= 1'b0;
      request_mole_q  <= 1'b0;
      mole_location_q <= 3'd0;
      full_q          <= 1'b0;
      recording_q     <= 1'b0;
    end else begin
      state_q         <= state_d;
      count_q         <= count_d;
      rd_ptr_q        <= rd_ptr_d;
      last_addr_q     <= last_addr_d;
      prev_one_q      <= one_hot;
      request_mole_q  <= request_mole_d;
      mole_location_q <= mole_location_d;
      full_q          <= full_d;
      recording_q     <= recording_d;
    end
  end

  // NOTE: entry storage is deliberately not reset; count masks stale contents.
  always_ff @(posedge clk) begin
    if (wr_en) mem[count_q[IDX_W-1:0]] <= wr_entry;
  end

  assign request_mole  = request_mole_q;
  assign mole_location = mole_location_q;
  assign count         = count_q;
  assign full          = full_q;
  assign recording     = recording_q;

endmodule

// File: tb/tb_mole_recorder.sv
// Directed bench for mole_recorder: recording, playback, rejection, full, priority/reset, empty.
module tb_mole_recorder;
  localparam int DEPTH  = 16;
  localparam int ADDR_W = 23;

  logic              clk = 1'b0;
  logic              reset;
  logic              diy_mode;
  logic              play;
  logic [7:0]        stomp;
  logic [ADDR_W-1:0] music_address;
  logic              request_mole;
  logic [2:0]        mole_location;
  logic [4:0]        count;
  logic              full;
  logic              recording;

  int checks   = 0;
  int failures = 0;

  mole_recorder #(.DEPTH(DEPTH), .ADDR_W(ADDR_W)) dut (
    .clk(clk), .reset(reset), .diy_mode(diy_mode), .play(play), .stomp(stomp),
    .music_address(music_address), .request_mole(request_mole),
    .mole_location(mole_location), .count(count), .full(full), .recording(recording)
  );

  always #5 clk = ~clk;

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic press(input logic [7:0] pad, input logic [ADDR_W-1:0] addr);
    stomp = pad; music_address = addr; tick();
    stomp = 8'h00; tick();
  endtask

  task automatic test_reset();
    reset = 1'b1; diy_mode = 1'b0; play = 1'b0; stomp = 8'h00; music_address = '0;
    tick(); tick();
    checks++; if (request_mole !== 1'b0) begin failures++; $display("FAIL reset_req got=%b exp=0", request_mole); end
    checks++; if (mole_location !== 3'd0) begin failures++; $display("FAIL reset_loc got=%0d exp=0", mole_location); end
    checks++; if (count !== 5'd0) begin failures++; $display("FAIL reset_count got=%0d exp=0", count); end
    checks++; if (full !== 1'b0) begin failures++; $display("FAIL reset_full got=%b exp=0", full); end
    checks++; if (recording !== 1'b0) begin failures++; $display("FAIL reset_rec got=%b exp=0", recording); end
    reset = 1'b0; tick();
  endtask

  task automatic test_record();
    diy_mode = 1'b1; tick(); tick();
    checks++; if (recording !== 1'b1) begin failures++; $display("FAIL rec_enter got=%b exp=1", recording); end
    press(8'h80, 23'h1000);
    checks++; if (count !== 5'd1) begin failures++; $display("FAIL rec_first got=%0d exp=1", count); end
    press(8'h01, 23'h2000);
    diy_mode = 1'b0; tick();
    checks++; if (count !== 5'd2) begin failures++; $display("FAIL rec_count got=%0d exp=2", count); end
    checks++; if (recording !== 1'b0) begin failures++; $display("FAIL rec_exit got=%b exp=0", recording); end
  endtask

  task automatic test_playback();
    int pa [6]   = '{32'h0FFF, 32'h1000, 32'h1001, 32'h2000, 32'h2000, 32'h3000};
    logic er [6] = '{1'b0, 1'b1, 1'b0, 1'b1, 1'b0, 1'b0};
    int el [6]   = '{0, 0, 0, 7, 7, 7};
    int pulses   = 0;
    play = 1'b1; music_address = 23'h0800; tick();
    for (int k = 0; k < 6; k++) begin
      music_address = 23'(pa[k]); tick();
      if (request_mole === 1'b1) pulses++;
      checks++; if (request_mole !== er[k]) begin failures++; $display("FAIL play_req step=%0d got=%b exp=%b", k, request_mole, er[k]); end
      checks++; if (mole_location !== 3'(el[k])) begin failures++; $display("FAIL play_loc step=%0d got=%0d exp=%0d", k, mole_location, el[k]); end
    end
    checks++; if (pulses != 2) begin failures++; $display("FAIL play_pulses got=%0d exp=2", pulses); end
    play = 1'b0; tick();
  endtask

  task automatic test_rejection();
    diy_mode = 1'b1; tick(); tick();
    press(8'h02, 23'h2000);
    checks++; if (count !== 5'd1) begin failures++; $display("FAIL rej_base got=%0d exp=1", count); end
    press(8'h81, 23'h3000);
    checks++; if (count !== 5'd1) begin failures++; $display("FAIL rej_multi got=%0d exp=1", count); end
    stomp = 8'h80; music_address = 23'h1000; tick();
    stomp = 8'h40; music_address = 23'h5000; tick();
    stomp = 8'h00; tick();
    checks++; if (count !== 5'd1) begin failures++; $display("FAIL rej_slide got=%0d exp=1", count); end
    press(8'h20, 23'h2000);
    checks++; if (count !== 5'd1) begin failures++; $display("FAIL rej_repeat got=%0d exp=1", count); end
    press(8'h20, 23'h2001);
    checks++; if (count !== 5'd2) begin failures++; $display("FAIL rej_accept got=%0d exp=2", count); end
    diy_mode = 1'b0; tick();
  endtask

  task automatic test_full();
    diy_mode = 1'b1; tick(); tick();
    for (int i = 0; i < 17; i++) begin
      press(8'(1 << (i % 8)), 23'((i + 1) * 256));
      checks++; if (count !== 5'((i + 1 > 16) ? 16 : i + 1)) begin failures++; $display("FAIL full_count i=%0d got=%0d", i, count); end
      checks++; if (full !== (i >= 15)) begin failures++; $display("FAIL full_flag i=%0d got=%b exp=%b", i, full, (i >= 15)); end
    end
    diy_mode = 1'b0; tick();
  endtask

  task automatic test_priority_reset();
    diy_mode = 1'b1; play = 1'b1; tick();
    checks++; if (recording !== 1'b0 || count !== 5'd16) begin failures++; $display("FAIL prio_clear rec=%b count=%0d exp rec=0 count=16", recording, count); end
    tick();
    checks++; if (recording !== 1'b1 || count !== 5'd0 || full !== 1'b0) begin failures++; $display("FAIL prio_record rec=%b count=%0d full=%b exp 1/0/0", recording, count, full); end
    play = 1'b0;
    press(8'h04, 23'h4000);
    diy_mode = 1'b0; tick();
    play = 1'b1; music_address = '0; tick();
    music_address = 23'h4000; reset = 1'b1; tick();
    checks++; if (request_mole !== 1'b0) begin failures++; $display("FAIL rst_play_req got=%b exp=0", request_mole); end
    checks++; if (count !== 5'd0) begin failures++; $display("FAIL rst_play_count got=%0d exp=0", count); end
    reset = 1'b0; play = 1'b0; tick();
  endtask

  task automatic test_empty();
    int pulses = 0;
    play = 1'b1; music_address = 23'h4000;
    for (int k = 0; k < 4; k++) begin
      tick();
      if (request_mole !== 1'b0) pulses++;
    end
    checks++; if (pulses != 0) begin failures++; $display("FAIL empty_pulses got=%0d exp=0", pulses); end
    checks++; if (count !== 5'd0 || recording !== 1'b0) begin failures++; $display("FAIL empty_state count=%0d rec=%b exp 0/0", count, recording); end
    play = 1'b0; tick();
  endtask

  initial begin
    test_reset();
    test_record();
    test_playback();
    test_rejection();
    test_full();
    test_priority_reset();
    test_empty();
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
